lshift_unit: RTL and testbench
==============================

// Module: lshift_unit
// PURPOSE
//  - 32-bit logical left barrel shifter for the processor ALU shift path.
//  - Combinational result: operand << shift_amt, zero-filled from the LSB.
//  - A one-cycle registered copy with a valid qualifier is also provided for
//    pipelined consumers.
// PARAMETERS
//  - WIDTH    32               data width; must be a power of two >= 2
//  - SHAMT_W  $clog2(WIDTH)=5  shift-amount width; derived, not overridable
// PORTS
//  - clk        in   1        rising-edge clock
//  - rst_n      in   1        asynchronous active-low reset
//  - operand    in   WIDTH    value to shift
//  - shift_amt  in   SHAMT_W  shift distance, 0..WIDTH-1
//  - in_valid   in   1        operand/shift_amt qualifier for the registered path
//  - result     out  WIDTH    combinational operand << shift_amt
//  - result_q   out  WIDTH    result registered on clk
//  - out_valid  out  1        in_valid delayed by 1 cycle
// BEHAVIOUR
//  - Clocking: one clock, clk. Reset rst_n is asynchronous and active-low.
//  - result:
//    - Pure combinational; zero latency, no dependence on clk or rst_n.
//    - result[i] = operand[i-shift_amt] for i >= shift_amt, else 0.
//    - Bits shifted past the MSB are discarded.
//    - Logical shift only: no arithmetic mode, no rotate.
//  - shift_amt = 0: result = operand unchanged.
//  - shift_amt = 31: result = {operand[0], 31'b0}.
//  - shift_amt is exactly SHAMT_W bits, so no out-of-range amounts exist.
//  - Implementation: log2(WIDTH) cascaded mux stages.
//    - Stage k shifts by 2^k when shift_amt[k] = 1.
//    - Stage order is LSB first.
//  - Registered path, on rising clk:
//    - result_q <= result when in_valid = 1; holds otherwise.
//    - out_valid <= in_valid every cycle.
//  - Reset:
//    - rst_n low forces result_q = 0 and out_valid = 0 immediately, asynchronously.
//    - Reset mid-operation discards the in-flight value.
//    - First capture is on the first rising clk after rst_n deasserts.
//  - No X propagation from the registered path after reset.
// CONFIGURATION
//  - Macro LSHIFT_OVERFLOW_EN enables port "ovf out 1".
//  - Defined:
//    - ovf = 1 iff any 1 bit of operand is shifted out, i.e. any bit among
//      operand[WIDTH-1 : WIDTH-shift_amt] is 1.
//    - ovf is combinational.
//    - A registered copy ovf_q follows the same rules as result_q.
//    - ovf_q resets to 0.
//  - Undefined: ports ovf and ovf_q are absent; all other behaviour is identical.
// STRUCTURE
//  - Package lshift_pkg:
//    - LSHIFT_WIDTH = 32
//    - LSHIFT_SHAMT_W = 5
//    - typedef word_t
//    - typedef shamt_t
//  - Sub-module lshift_stage (parameter K):
//    - Conditional shift by 2^K.
//    - Instantiated SHAMT_W times by a generate loop.
//  - Top-level logic: stage chain, optional ovf, output/valid registers.
// TESTING
//  - operand=0xF1A7372F, shift_amt=0 -> result=0xF1A7372F
//  - operand=0xF1A7372F, shift_amt=1 -> result=0xE34E6E5E, ovf=1
//  - operand=0xF1A7372F, shift_amt=4 -> result=0x1A7372F0
//  - operand=0xF1A7372F, shift_amt=31 -> result=0x80000000
//  - operand=0xF1A7372F, sweep shift_amt 0..31 with 20-time-unit settle:
//    - result == operand<<i every step
//    - expect 32/32 pass
//  - in_valid=1, operand=0x00000001, shift_amt=31:
//    - next clk: result_q=0x80000000, out_valid=1, ovf_q=0
//    - assert rst_n=0 between edges: result_q=0, out_valid=0 at once, without a clk edge

Source files
------------

// File: rtl/lshift_pkg.sv
// Shared constants and types for the 32-bit logical left shifter.
package lshift_pkg;

  localparam int LSHIFT_WIDTH   = 32;
  localparam int LSHIFT_SHAMT_W = $clog2(LSHIFT_WIDTH);

  typedef logic [LSHIFT_WIDTH-1:0]   word_t;
  typedef logic [LSHIFT_SHAMT_W-1:0] shamt_t;

endpackage : lshift_pkg

// File: rtl/lshift_if.sv
// Operand/result bundle of the shifter; ovf/ovf_q exist only when LSHIFT_OVERFLOW_EN is defined.
interface lshift_if
  import lshift_pkg::*;
#(
  parameter int WIDTH = LSHIFT_WIDTH
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shift_amt;
  logic               in_valid;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_q;
  logic               out_valid;
`ifdef LSHIFT_OVERFLOW_EN
  logic               ovf;
  logic               ovf_q;
`endif

  modport master (
    output operand,
    output shift_amt,
    output in_valid,
    input  result,
    input  result_q,
`ifdef LSHIFT_OVERFLOW_EN
    input  ovf,
    input  ovf_q,
`endif
    input  out_valid
  );

  modport slave (
    input  operand,
    input  shift_amt,
    input  in_valid,
    output result,
    output result_q,
`ifdef LSHIFT_OVERFLOW_EN
    output ovf,
    output ovf_q,
`endif
    output out_valid
  );

endinterface : lshift_if

// File: rtl/lshift_stage.sv
// One barrel-shifter stage: conditionally shifts left by 2**K, zero-filling the LSBs.
module lshift_stage
  import lshift_pkg::*;
#(
  parameter int WIDTH = LSHIFT_WIDTH,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  output logic [WIDTH-1:0] data_out
);

  localparam int SH = 1 << K;

  logic [WIDTH-1:0] shifted;

  assign shifted  = data_in << SH;
  assign data_out = en ? shifted : data_in;

endmodule : lshift_stage

// File: rtl/lshift_unit.sv
// Logical left barrel shifter with combinational result and a registered, valid-qualified copy.
// Optional overflow flag (ovf/ovf_q) is built when LSHIFT_OVERFLOW_EN is defined.
module lshift_unit
  import lshift_pkg::*;
#(
  parameter int WIDTH = LSHIFT_WIDTH  // power of two >= 2
) (
  input  logic   clk,
  input  logic   rst_n,
  lshift_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] stage_data [SHAMT_W+1];
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] res_q;
  logic             vld_d;
  logic             vld_q;

  // Stage chain, LSB first: stage gi shifts by 2**gi when shift_amt[gi] is set.
  assign stage_data[0] = bus.operand;

  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      lshift_stage #(
        .WIDTH (WIDTH),
        .K     (gi)
      ) u_stage (
        .data_in  (stage_data[gi]),
        .en       (bus.shift_amt[gi]),
        .data_out (stage_data[gi+1])
      );
    end
  endgenerate

  assign result     = stage_data[SHAMT_W];
  assign bus.result = result;

`ifdef LSHIFT_OVERFLOW_EN
  logic [WIDTH-1:0] ovf_mask;
  logic             ovf;
  logic             ovf_d;
  logic             ovf_q;

  // Mask covers the top shift_amt bits, i.e. exactly those pushed past the MSB.
  assign ovf_mask = ~({WIDTH{1'b1}} >> bus.shift_amt);
  assign ovf      = |(bus.operand & ovf_mask);
  assign bus.ovf  = ovf;
`endif

  always_comb begin
    res_d = res_q;
    vld_d = bus.in_valid;
    if (bus.in_valid) begin
      res_d = result;
    end
`ifdef LSHIFT_OVERFLOW_EN
    ovf_d = ovf_q;
    if (bus.in_valid) begin
      ovf_d = ovf;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
`ifdef LSHIFT_OVERFLOW_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
`ifdef LSHIFT_OVERFLOW_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign bus.result_q  = res_q;
  assign bus.out_valid = vld_q;
`ifdef LSHIFT_OVERFLOW_EN
  assign bus.ovf_q     = ovf_q;
`endif

endmodule : lshift_unit

// File: tb/tb_lshift_unit.sv
// Self-checking bench for lshift_unit: directed vectors plus an arithmetic reference model.
module tb_lshift_unit;
  import lshift_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  lshift_if bus ();

  lshift_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on a widened value.
  function automatic word_t model_shift(input word_t op, input shamt_t s);
    logic [63:0] w;
    w = {32'b0, op} << s;
    return w[31:0];
  endfunction

  function automatic logic model_ovf(input word_t op, input shamt_t s);
    logic [63:0] w;
    w = {32'b0, op} << s;
    return |w[63:32];
  endfunction

  word_t exp_res_q;
  logic  exp_vld;
  logic  exp_ovf_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_res_q <= '0;
      exp_vld   <= 1'b0;
      exp_ovf_q <= 1'b0;
    end else begin
      exp_vld <= bus.in_valid;
      if (bus.in_valid) begin
        exp_res_q <= model_shift(bus.operand, bus.shift_amt);
        exp_ovf_q <= model_ovf(bus.operand, bus.shift_amt);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_result", bus.result, model_shift(bus.operand, bus.shift_amt));
      chk("cyc_result_q", bus.result_q, exp_res_q);
      chk("cyc_out_valid", {31'b0, bus.out_valid}, {31'b0, exp_vld});
`ifdef LSHIFT_OVERFLOW_EN
      chk("cyc_ovf", {31'b0, bus.ovf}, {31'b0, model_ovf(bus.operand, bus.shift_amt)});
      chk("cyc_ovf_q", {31'b0, bus.ovf_q}, {31'b0, exp_ovf_q});
`endif
    end
  end

  // Inputs always change 2 time units after a rising edge.
  task automatic wait_slot();
    @(posedge clk);
    #2;
  endtask

  shamt_t lit_s [4] = '{5'd0, 5'd1, 5'd4, 5'd31};
  word_t  lit_r [4] = '{32'hF1A7372F, 32'hE34E6E5E, 32'h1A7372F0, 32'h80000000};
  logic   lit_o [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int sweep_pass;
    bus.operand   = '0;
    bus.shift_amt = '0;
    bus.in_valid  = 1'b0;
    cmp_en        = 1'b1;

    wait_slot();
    wait_slot();
    chk("reset_result_q", bus.result_q, 32'h0);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
    rst_n = 1'b1;

    // Directed literals on the combinational path.
    bus.operand = 32'hF1A7372F;
    for (int i = 0; i < 4; i++) begin
      bus.shift_amt = lit_s[i];
      #1;
      $display("lit: op=0x%08h sh=%0d result=0x%08h", bus.operand, bus.shift_amt, bus.result);
      chk("lit_result", bus.result, lit_r[i]);
`ifdef LSHIFT_OVERFLOW_EN
      chk("lit_ovf", {31'b0, bus.ovf}, {31'b0, lit_o[i]});
`else
      if (lit_o[i] !== model_ovf(bus.operand, bus.shift_amt)) begin
        failures++;
        $display("FAIL model_ovf got=%0b exp=%0b", model_ovf(bus.operand, bus.shift_amt), lit_o[i]);
      end
      checks++;
`endif
    end

    // Full sweep of shift amounts with the registered path capturing.
    wait_slot();
    bus.in_valid = 1'b1;
    sweep_pass = 0;
    for (int i = 0; i < 32; i++) begin
      bus.shift_amt = shamt_t'(i);
      #20;
      checks++;
      if (bus.result === (32'hF1A7372F << i)) begin
        sweep_pass++;
      end else begin
        failures++;
        $display("FAIL sweep sh=%0d got=0x%08h exp=0x%08h", i, bus.result, 32'hF1A7372F << i);
      end
    end
    $display("sweep: %0d/32 pass", sweep_pass);

    // Hold: result_q must not change while in_valid is low.
    bus.in_valid  = 1'b0;
    bus.operand   = 32'h12345678;
    bus.shift_amt = 5'd7;
    wait_slot();
    wait_slot();
    chk("hold_result_q", bus.result_q, 32'h80000000);

    // Single-cycle capture of 1 << 31.
    bus.operand   = 32'h00000001;
    bus.shift_amt = 5'd31;
    bus.in_valid  = 1'b1;
    wait_slot();
    $display("cap: op=0x%08h sh=%0d result_q=0x%08h out_valid=%0b", bus.operand, bus.shift_amt,
             bus.result_q, bus.out_valid);
    chk("cap_result_q", bus.result_q, 32'h80000000);
    chk("cap_out_valid", {31'b0, bus.out_valid}, 32'h1);
`ifdef LSHIFT_OVERFLOW_EN
    chk("cap_ovf_q", {31'b0, bus.ovf_q}, 32'h0);
`endif

    // Asynchronous reset between edges, held across an edge with in_valid high.
    bus.operand   = 32'hDEADBEEF;
    bus.shift_amt = 5'd4;
    wait_slot();
    chk("pre_rst_result_q", bus.result_q, 32'hEADBEEF0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_result_q", bus.result_q, 32'h0);
    chk("async_rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    wait_slot();
    chk("held_rst_result_q", bus.result_q, 32'h0);
    rst_n = 1'b1;
    wait_slot();
    chk("post_rst_result_q", bus.result_q, 32'hEADBEEF0);
    chk("post_rst_out_valid", {31'b0, bus.out_valid}, 32'h1);

    // Random vectors, checked every cycle by the compare process.
    for (int i = 0; i < 20; i++) begin
      bus.operand   = $urandom;
      bus.shift_amt = shamt_t'($urandom_range(0, 31));
      bus.in_valid  = 1'($urandom_range(0, 1));
      wait_slot();
      $display("rnd: op=0x%08h sh=%0d iv=%0b result=0x%08h result_q=0x%08h", bus.operand,
               bus.shift_amt, bus.in_valid, bus.result, bus.result_q);
    end

    wait_slot();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lshift_unit
